// File: rtl/log_reader.sv
// log_reader: drains entries 0..count-1 from a synchronous-read RAM onto a
// valid/ready output, optionally pulsing a RAM clear once the drain is done.
// Each entry costs at least three cycles: ADDR issues the read, CAPT registers
// the returned data, and EMIT holds it until the consumer takes it.
module log_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 37,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic                  clr_after,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  re,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  clr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADDR  = 3'd1;
  localparam logic [2:0] CAPT  = 3'd2;
  localparam logic [2:0] EMIT  = 3'd3;
  localparam logic [2:0] CLEAR = 3'd4;
  localparam logic [2:0] FIN   = 3'd5;

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

  logic [2:0]          state, state_nxt;
  logic [ADDR_WIDTH:0] ptr, cnt, ptr_inc, cnt_clip;
  logic                clr_lat;
  logic                take;      // accepted start
  logic                hs;        // consumer handshake that is not overridden by abort

  // ptr never exceeds the clipped count, so the increment cannot wrap
  assign ptr_inc  = ptr + PTR_ONE;
  assign cnt_clip = (count > DEPTH_C) ? DEPTH_C : count;
  assign take     = (state == IDLE) && start;
  assign hs       = (state == EMIT) && out_ready && !abort;

  // Next-state decode; abort overrides every transition out of a busy state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (cnt_clip == '0) ? FIN : ADDR;
      ADDR:    state_nxt = CAPT;
      CAPT:    state_nxt = EMIT;
      EMIT: begin
        if (out_ready) begin
          if (ptr_inc < cnt)  state_nxt = ADDR;
          else if (clr_lat)   state_nxt = CLEAR;
          else                state_nxt = FIN;
        end
      end
      CLEAR:   state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) state_nxt = IDLE;
  end

  // State register plus the drain bookkeeping latched on an accepted start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      clr_lat <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        ptr     <= '0;
        cnt     <= cnt_clip;
        clr_lat <= clr_after;
      end else if (hs) begin
        ptr <= ptr_inc;
      end
    end
  end

  // Output holding register: loaded in CAPT, held through EMIT until taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      out_valid <= 1'b0;
    end else if (state == CAPT) begin
      out_data  <= rd_data;
      out_valid <= 1'b1;
    end else if (hs) begin
      out_valid <= 1'b0;
    end
  end

  // Control outputs decode straight from state; abort suppresses the
  // completion-side pulses so a cancelled drain never reports done or clears
  always_comb begin
    rd_addr = ptr[ADDR_WIDTH-1:0];
    re      = (state == ADDR) || (state == CAPT);
    busy    = (state != IDLE);
    clr     = (state == CLEAR) && !abort;
    done    = (state == FIN) && !abort;
  end

endmodule

// File: tb/tb_log_reader.sv
// Bench for log_reader: a synchronous-read RAM model, a queue-based
// scoreboard fed at start time, and a negedge monitor that checks every
// handshake, clear and done pulse as the DUT presents them.
module tb_log_reader;
  localparam int AW    = 8;
  localparam int DW    = 37;
  localparam int DEPTH = 64;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          start = 1'b0, clr_after = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [AW:0]   count = '0;
  logic [AW-1:0] rd_addr;
  logic          re, clr, out_valid, busy, done;
  logic [DW-1:0] rd_data, out_data;

  log_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .count(count),
    .clr_after(clr_after), .abort(abort), .rd_addr(rd_addr), .re(re),
    .rd_data(rd_data), .clr(clr), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done));

  always #5 clk = ~clk;

  // RAM: registered read when re, junk otherwise so a mistimed capture shows
  logic [DW-1:0] ram [256];
  always @(posedge clk) rd_data <= re ? ram[rd_addr] : DW'({$urandom, $urandom});

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, passed = 0;
  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model state: expected entries and pending pulses
  logic [DW-1:0] expq[$];
  int exp_done = 0, exp_clr = 0;

  // Per-test recorder filled by the monitor
  int hs_cyc[$];
  int done_cyc = -1, clr_cyc = -1, re_cnt = 0, last_addr = -1;

  task automatic rec_clear();
    hs_cyc.delete(); done_cyc = -1; clr_cyc = -1; re_cnt = 0; last_addr = -1;
  endtask

  task automatic model_flush();
    expq.delete(); exp_done = 0; exp_clr = 0;
  endtask

  // Monitor: consumes the scoreboard whenever the DUT presents an event
  initial begin
    bit hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) chk(out_valid && out_data == hold_d, "hold_stable", out_data, hold_d);
        if (out_valid) chk(!re, "re_in_emit", re, 0);
        if (out_valid && out_ready && !abort) begin
          hs_cyc.push_back(cyc);
          if (expq.size() == 0) chk(1'b0, "unexpected_entry", out_data, 0);
          else begin
            e = expq.pop_front();
            chk(out_data == e, "out_data", out_data, e);
          end
        end
        if (re) begin re_cnt++; last_addr = int'(rd_addr); end
        if (clr) begin
          clr_cyc = cyc;
          chk(exp_clr > 0, "clr_expected", 1, exp_clr);
          if (exp_clr > 0) exp_clr--;
        end
        if (done) begin
          done_cyc = cyc;
          chk(exp_done > 0, "done_expected", 1, exp_done);
          chk(expq.size() == 0, "done_with_entries_left", expq.size(), 0);
          if (exp_done > 0) exp_done--;
        end
        hold_v = out_valid && !out_ready && !abort;
        hold_d = out_data;
      end
    end
  end

  // Consumer back-pressure when randomised
  bit rdy_rand = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Model: an accepted start queues entries 0..min(n,DEPTH)-1
  task automatic model_start(input int n, input bit ca);
    int c;
    c = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < c; i++) expq.push_back(ram[i]);
    exp_done++;
    if (ca && c > 0) exp_clr++;
  endtask

  task automatic do_start(input int n, input bit ca);
    start = 1'b1; count = (AW+1)'(n); clr_after = ca;
    if (!busy) model_start(n, ca);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin tick(); k++; end
    chk(!busy, "idle_timeout", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = DW'({$urandom, $urandom});
    ram[0] = 1; ram[1] = 2; ram[2] = 3;

    // Reset state
    #2;
    chk({rd_addr, re, clr, out_valid, busy, done} == '0 && out_data == '0,
        "reset_outputs", {rd_addr, re, clr, out_valid, busy, done}, 0);

    // Three entries, always ready; start on the first edge after reset release
    @(negedge clk); @(negedge clk);
    rec_clear();
    reset_n = 1'b1; start = 1'b1; count = 3; clr_after = 1'b0; out_ready = 1'b1;
    model_start(3, 1'b0);
    tick(); start = 1'b0;
    chk(busy, "start_after_reset", busy, 1);
    wait_idle(50);
    chk(hs_cyc.size() == 3, "t1_entries", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) begin
      chk(hs_cyc[1] - hs_cyc[0] == 3, "t1_gap0", hs_cyc[1] - hs_cyc[0], 3);
      chk(hs_cyc[2] - hs_cyc[1] == 3, "t1_gap1", hs_cyc[2] - hs_cyc[1], 3);
      chk(done_cyc == hs_cyc[2] + 1, "t1_done_time", done_cyc, hs_cyc[2] + 1);
    end
    chk(clr_cyc == -1, "t1_no_clr", clr_cyc, -1);

    // Back-pressure on the first entry
    for (int i = 0; i < 3; i++) ram[i] = DW'({$urandom, $urandom});
    rec_clear(); out_ready = 1'b0;
    do_start(2, 1'b0);
    for (int k = 0; k < 10 && !out_valid; k++) tick();
    chk(out_valid, "t2_valid", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk(out_valid && !re && out_data == ram[0], "t2_stall", out_data, ram[0]);
    end
    out_ready = 1'b1;
    wait_idle(50);
    chk(hs_cyc.size() == 2, "t2_entries", hs_cyc.size(), 2);

    // Zero count: one busy cycle that is FIN, no reads
    rec_clear();
    do_start(0, 1'b1);
    chk(busy && done, "t3_fin", {busy, done}, 3);
    tick();
    chk(!busy, "t3_idle", busy, 0);
    chk(re_cnt == 0 && clr_cyc == -1 && done_cyc != -1, "t3_no_read", re_cnt, 0);

    // Count clipped to DEPTH with a trailing clear
    rec_clear();
    do_start(100, 1'b1);
    wait_idle(400);
    chk(hs_cyc.size() == DEPTH, "t4_entries", hs_cyc.size(), DEPTH);
    chk(last_addr == DEPTH - 1, "t4_last_addr", last_addr, DEPTH - 1);
    if (hs_cyc.size() > 0) chk(clr_cyc == hs_cyc[$] + 1, "t4_clr_time", clr_cyc, hs_cyc[$] + 1);
    chk(done_cyc == clr_cyc + 1, "t4_done_time", done_cyc, clr_cyc + 1);

    // Abort during the second EMIT, then restart
    rec_clear();
    do_start(4, 1'b1);
    for (int k = 0; k < 20 && hs_cyc.size() < 1; k++) tick();
    for (int k = 0; k < 10 && !out_valid; k++) tick();
    abort = 1'b1; model_flush();
    tick(); abort = 1'b0;
    chk(!busy && !out_valid, "t5_abort_idle", {busy, out_valid}, 0);
    tick(); tick();
    chk(hs_cyc.size() == 1 && done_cyc == -1 && clr_cyc == -1, "t5_no_done", done_cyc, -1);
    do_start(2, 1'b0);
    wait_idle(50);
    chk(hs_cyc.size() == 3 && done_cyc != -1, "t5_restart", hs_cyc.size(), 3);

    // Reset between edges while in CAPT; a start while busy is ignored
    rec_clear();
    do_start(3, 1'b1);
    do_start(5, 1'b0);
    chk(re && !out_valid, "t6_in_capt", re, 1);
    #2; reset_n = 1'b0; model_flush();
    #1;
    chk({rd_addr, re, clr, out_valid, busy, done} == '0 && out_data == '0,
        "t6_async_reset", {rd_addr, re, clr, out_valid, busy, done}, 0);
    @(negedge clk); reset_n = 1'b1;
    tick(); tick(); tick();
    chk(!busy && done_cyc == -1 && clr_cyc == -1, "t6_discarded", done_cyc, -1);

    // Randomised drains with back-pressure, stray starts and aborts
    rdy_rand = 1'b1;
    for (int it = 0; it < 30; it++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int k = 0; k < gap; k++) tick();
      do_start($urandom_range(0, 70), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) do_start($urandom_range(1, 5), 1'b0);
      if ($urandom_range(0, 5) == 0) begin
        gap = $urandom_range(1, 20);
        for (int k = 0; k < gap; k++) tick();
        if (busy) begin abort = 1'b1; model_flush(); end
        tick(); abort = 1'b0;
      end
      wait_idle(1000);
      tick();
      chk(expq.size() == 0 && exp_done == 0 && exp_clr == 0, "rand_drained",
          expq.size(), 0);
    end
    rdy_rand = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
